// File: rtl/sram_ctrl.sv
// Single-port async SRAM controller: fixed SETUP/ACCESS/HOLD timing, all outputs registered.
// Ports: CPU side RAMreq/RAMaddr/RAMwrite/RAMbe/RAMwe -> RAMread/RAMack/RAMbusy; SRAM side sram_*.
module sram_ctrl #(
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RAMreq,
  input  logic [15:0] RAMaddr,
  input  logic [15:0] RAMwrite,
  input  logic [1:0]  RAMbe,
  input  logic        RAMwe,
  output logic [15:0] RAMread,
  output logic        RAMack,
  output logic        RAMbusy,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } state_e;

  localparam logic [3:0] WS_M1 = 4'(WAIT_STATES - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] dqout_q, dqout_d;
  logic [1:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        dqoe_q, dqoe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dqout_d = dqout_q;
    be_d    = be_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (RAMreq) begin
          state_d = SETUP;
          addr_d  = RAMaddr;
          be_d    = RAMbe;
          we_d    = RAMwe;
          if (RAMwe) dqout_d = RAMwrite;
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = WS_M1;
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = HOLD;
          ack_d   = 1'b1;
          // capture on the edge that ends the last access cycle
          if (!we_q && (be_q != 2'b00)) rdata_d = sram_dq_in;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // strobes are decoded from the next state so they leave flops cleanly
    busy_d = (state_d != IDLE);
    ce_n_d = ~busy_d;
    ub_n_d = busy_d ? ~be_d[1] : 1'b1;
    lb_n_d = busy_d ? ~be_d[0] : 1'b1;
    dqoe_d = busy_d & we_d;
    we_n_d = ~((state_d == ACCESS) & we_d);
    oe_n_d = ~((state_d == ACCESS) & ~we_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      dqout_q <= 16'h0000;
      be_q    <= 2'b00;
      we_q    <= 1'b0;
      rdata_q <= 16'h0000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      dqoe_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dqout_q <= dqout_d;
      be_q    <= be_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      dqoe_q  <= dqoe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
    end
  end

  assign RAMread     = rdata_q;
  assign RAMack      = ack_q;
  assign RAMbusy     = busy_q;
  assign sram_addr   = addr_q;
  assign sram_dq_out = dqout_q;
  assign sram_dq_oe  = dqoe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_ub_n   = ub_n_q;
  assign sram_lb_n   = lb_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl (WAIT_STATES=2).
// Stimulus queues per-cycle expected outputs; a negedge monitor pops and compares.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        RAMreq;
  logic [15:0] RAMaddr;
  logic [15:0] RAMwrite;
  logic [1:0]  RAMbe;
  logic        RAMwe;
  logic [15:0] RAMread;
  logic        RAMack;
  logic        RAMbusy;
  logic [15:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        sram_ub_n;
  logic        sram_lb_n;

  sram_ctrl #(.WAIT_STATES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .RAMreq      (RAMreq),
    .RAMaddr     (RAMaddr),
    .RAMwrite    (RAMwrite),
    .RAMbe       (RAMbe),
    .RAMwe       (RAMwe),
    .RAMread     (RAMread),
    .RAMack      (RAMack),
    .RAMbusy     (RAMbusy),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_oe  (sram_dq_oe),
    .sram_dq_in  (sram_dq_in),
    .sram_ce_n   (sram_ce_n),
    .sram_oe_n   (sram_oe_n),
    .sram_we_n   (sram_we_n),
    .sram_ub_n   (sram_ub_n),
    .sram_lb_n   (sram_lb_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model
  logic [15:0] mem [0:255];
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hDEAD;
  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
      if (!sram_ub_n) mem[sram_addr[7:0]][15:8] <= sram_dq_out[15:8];
      if (!sram_lb_n) mem[sram_addr[7:0]][7:0]  <= sram_dq_out[7:0];
    end
  end

  typedef struct {
    int          cyc;
    logic [55:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int fails  = 0;

  logic [15:0] m_addr, m_dq, m_rd;

  function automatic logic [55:0] mk(
    input logic ack, input logic busy, input logic ce, input logic oe,
    input logic we, input logic ub, input logic lb, input logic dqoe,
    input logic [15:0] a, input logic [15:0] d, input logic [15:0] r);
    return {ack, busy, ce, oe, we, ub, lb, dqoe, a, d, r};
  endfunction

  task automatic push(input int c, input logic [55:0] v, input string nm);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    e.nm  = nm;
    q.push_back(e);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // monitor: compare every expected cycle, stimulus-independent
  always @(negedge clk) begin
    logic [55:0] act;
    act = {RAMack, RAMbusy, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n,
           sram_lb_n, sram_dq_oe, sram_addr, sram_dq_out, RAMread};
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++;
      fails++;
      $display("FAIL %s stale entry cyc=%0d now=%0d", q[0].nm, q[0].cyc, cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      checks++;
      if (act !== q[0].v) begin
        fails++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", q[0].nm, cyc, act, q[0].v);
      end
      void'(q.pop_front());
    end
  end

  // one transfer; caller sits at start of the request cycle, returns at start of cycle c0+5
  task automatic xfer(input string nm, input logic [15:0] a, input logic [15:0] d,
                      input logic [1:0] be, input logic we, input logic [15:0] exp_rd,
                      input int intr, input int rst_at);
    int c0;
    logic [15:0] dqn, rnew;
    c0 = cyc;
    RAMreq = 1'b1; RAMaddr = a; RAMwrite = d; RAMbe = be; RAMwe = we;
    dqn  = we ? d : m_dq;
    rnew = (!we && be != 2'b00) ? exp_rd : m_rd;
    push(c0 + 1, mk(0, 1, 0, 1, 1, ~be[1], ~be[0], we, a, dqn, m_rd), {nm, ".setup"});
    push(c0 + 2, mk(0, 1, 0, we, ~we, ~be[1], ~be[0], we, a, dqn, m_rd), {nm, ".acc1"});
    if (rst_at == 0) begin
      push(c0 + 3, mk(0, 1, 0, we, ~we, ~be[1], ~be[0], we, a, dqn, m_rd), {nm, ".acc2"});
      push(c0 + 4, mk(1, 1, 0, 1, 1, ~be[1], ~be[0], we, a, dqn, rnew), {nm, ".hold"});
      push(c0 + 5, mk(0, 0, 1, 1, 1, 1, 1, 0, a, dqn, rnew), {nm, ".idle"});
      m_addr = a; m_dq = dqn; m_rd = rnew;
    end else begin
      for (int k = 3; k <= 5; k++)
        push(c0 + k, mk(0, 0, 1, 1, 1, 1, 1, 0, 16'h0, 16'h0, 16'h0),
             $sformatf("%s.rst%0d", nm, k));
      m_addr = 16'h0; m_dq = 16'h0; m_rd = 16'h0;
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      RAMreq = 1'b0;
      rst    = (k == rst_at);
      if (k == intr) begin
        RAMreq  = 1'b1;
        RAMaddr = 16'h0055;
        RAMwe   = ~we;
        RAMbe   = 2'b10;
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h13] = 16'h7700;
    mem[8'h20] = 16'hCAFE;
    m_addr = 16'h0; m_dq = 16'h0; m_rd = 16'h0;
    // reset with a coincident request that must be ignored
    rst = 1'b1; RAMreq = 1'b1; RAMaddr = 16'h0077; RAMwrite = 16'h1111;
    RAMbe = 2'b11; RAMwe = 1'b1;
    for (int c = 1; c <= 4; c++)
      push(c, mk(0, 0, 1, 1, 1, 1, 1, 0, 16'h0, 16'h0, 16'h0), $sformatf("reset.c%0d", c));
    step(); step(); step();
    rst = 1'b0; RAMreq = 1'b0;
    step();

    xfer("wr_word", 16'h0012, 16'hBEEF, 2'b11, 1'b1, 16'h0, 0, 0);
    xfer("wr_lo",   16'h0013, 16'h00A5, 2'b01, 1'b1, 16'h0, 0, 0);
    mem[8'h12] = 16'h1234;
    xfer("rd_b2b",  16'h0012, 16'h0000, 2'b11, 1'b0, 16'h1234, 0, 0);
    step();
    xfer("rd_hi",   16'h0020, 16'h0000, 2'b10, 1'b0, 16'hCAFE, 0, 0);
    xfer("rd_be0",  16'h0012, 16'h0000, 2'b00, 1'b0, 16'h0, 0, 0);
    xfer("wr_be0",  16'h0040, 16'h5A5A, 2'b00, 1'b1, 16'h0, 0, 0);
    xfer("wr_ign",  16'h0030, 16'h4321, 2'b11, 1'b1, 16'h0, 2, 0);
    xfer("wr_rst",  16'h0012, 16'hBEEF, 2'b11, 1'b1, 16'h0, 0, 2);
    step();
    xfer("rd_lo",   16'h0013, 16'h0000, 2'b11, 1'b0, 16'h77A5, 0, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    if (q.size() > 0) begin
      checks++;
      fails++;
      $display("FAIL drain timeout left=%0d", q.size());
    end
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
